// File: rtl/mult_share_sequencer_if.sv
// Handshake bundle between the two requesters, the result consumer and the
// shared multiplier sequencer. "master" is the requester/consumer side and
// "slave" is the sequencer side.
interface mult_share_sequencer_if #(
  parameter int AW = 3,
  parameter int BW = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [AW-1:0]     req0_a;
  logic [BW-1:0]     req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [AW-1:0]     req1_a;
  logic [BW-1:0]     req1_b;
  logic              res_valid;
  logic              res_ready;
  logic [AW+BW-1:0]  res_data;
  logic              res_id;
  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/mult_share_sequencer.sv
// Shared shift-add multiplier for two requesters. A round-robin arbiter picks
// one operand pair, then one partial-product row (op_a bit AND op_b, shifted)
// is accumulated per clock, which is the array multiplier folded in time.
// The product is offered on a valid/ready port tagged with the requester id.
module mult_share_sequencer #(
  parameter int AW = 3,
  parameter int BW = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mult_share_sequencer_if.slave bus
);

  localparam int PW = AW + BW;
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   op_a;
  logic [BW-1:0]   op_b;
  logic            res_id_q;
  logic            last_grant;
  logic            grant;
  logic            accept;
  logic            last_row;
  logic [PW-1:0]   row;

  assign last_row     = (cnt == CW'(AW - 1));
  assign accept       = bus.req0_ready | bus.req1_ready;
  assign bus.res_data = acc;
  assign bus.res_id   = res_id_q;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Current partial-product row: multiplicand gated by the selected multiplier bit.
  always_comb begin
    row = '0;
    if (op_a[cnt]) begin
      row = {{AW{1'b0}}, op_b} << cnt;
    end
  end

  // State register; reset aborts any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: accept in IDLE, run AW rows in CALC, wait for the consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (last_row) state_nxt = DONE;
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; ready is masked during reset so nothing looks accepted.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.res_valid  = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = rst_n && bus.req0_valid && !grant;
        bus.req1_ready = rst_n && bus.req1_valid && grant;
      end
      CALC: begin
        bus.busy = 1'b1;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  // Operand capture on acceptance and one accumulate step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_id_q   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? bus.req1_a : bus.req0_a;
            op_b       <= grant ? bus.req1_b : bus.req0_b;
            res_id_q   <= grant;
            last_grant <= grant;
            acc        <= '0;
            cnt        <= '0;
          end
        end
        CALC: begin
          acc <= acc + row;
          cnt <= cnt + 1'b1;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule
